// File: rtl/edge_exchange_tx.sv
// Boundary-exchange transmitter: snapshots first/last node positions on step_done into two
// independent valid/ready FIFOs. Define EDGE_TX_OVERWRITE_EN to overwrite the newest entry when full.
module edge_exchange_tx #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step_done_i,
   input  logic [W-1:0] first_x_i,
   input  logic [W-1:0] first_y_i,
   input  logic [W-1:0] last_x_i,
   input  logic [W-1:0] last_y_i,
   output logic         l_valid_o,
   input  logic         l_ready_i,
   output logic [W-1:0] l_x_o,
   output logic [W-1:0] l_y_o,
   output logic [7:0]   l_seq_o,
   output logic         r_valid_o,
   input  logic         r_ready_i,
   output logic [W-1:0] r_x_o,
   output logic [W-1:0] r_y_o,
   output logic [7:0]   r_seq_o,
   output logic         full_o,
   output logic         overflow_o,
   output logic [15:0]  drop_count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2*W + 8;
   typedef logic [AW:0] ptr_t;

   logic [EW-1:0] mem_q [2][DEPTH];
   ptr_t          wr_ptr_q [2];
   ptr_t          wr_ptr_d [2];
   ptr_t          rd_ptr_q [2];
   ptr_t          rd_ptr_d [2];
   logic [AW-1:0] waddr [2];
   logic [EW-1:0] wdata [2];
   logic [EW-1:0] head  [2];
   logic [1:0]    empty, ch_full, ready, pop, lose, we;
   logic [7:0]    seq_ctr_q, seq_ctr_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_count_q, drop_count_d;

   always_comb begin
      ready    = {r_ready_i, l_ready_i};
      wdata[0] = {first_x_i, first_y_i, seq_ctr_q};
      wdata[1] = {last_x_i, last_y_i, seq_ctr_q};
      for (int c = 0; c < 2; c++) begin
         empty[c]   = (wr_ptr_q[c] == rd_ptr_q[c]);
         ch_full[c] = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                      (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
         head[c]    = empty[c] ? '0 : mem_q[c][rd_ptr_q[c][AW-1:0]];
         pop[c]     = !empty[c] && ready[c];
         // a pop in the same cycle frees the slot the push needs
         lose[c]    = step_done_i && ch_full[c] && !pop[c];
         we[c]       = 1'b0;
         waddr[c]    = wr_ptr_q[c][AW-1:0];
         wr_ptr_d[c] = wr_ptr_q[c];
         rd_ptr_d[c] = rd_ptr_q[c] + ptr_t'(pop[c]);
         if (step_done_i && !lose[c]) begin
            we[c]       = 1'b1;
            wr_ptr_d[c] = wr_ptr_q[c] + ptr_t'(1);
         end
`ifdef EDGE_TX_OVERWRITE_EN
         if (lose[c]) begin
            we[c]    = 1'b1;
            waddr[c] = wr_ptr_q[c][AW-1:0] - AW'(1);
         end
`endif
      end
      seq_ctr_d    = step_done_i ? seq_ctr_q + 8'd1 : seq_ctr_q;
      overflow_d   = overflow_q | (|lose);
      drop_count_d = ((|lose) && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         seq_ctr_q    <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
         end
         seq_ctr_q    <= seq_ctr_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // storage is not reset; empty FIFOs gate the payload to zero
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (reset && we[c]) mem_q[c][waddr[c]] <= wdata[c];
      end
   end

   assign l_valid_o = !empty[0];
   assign r_valid_o = !empty[1];
   assign {l_x_o, l_y_o, l_seq_o} = head[0];
   assign {r_x_o, r_y_o, r_seq_o} = head[1];
   assign full_o       = |ch_full;
   assign overflow_o   = overflow_q;
   assign drop_count_o = drop_count_q;
endmodule

// File: doc/edge_exchange_tx.md
# edge_exchange_tx

Transmit side of the inter-core boundary exchange. At the end of each simulation step the sequencer pulses `step_done`; this block snapshots the core's first-node and last-node positions, tags them with a step sequence number and queues them on two independent valid/ready channels. The left channel feeds the previous core's `next_core_first_x/y` inputs; the right channel feeds the next core's `prev_core_last_x/y` inputs. Bounded buffering absorbs slow consumers, and a `full` back-pressure flag tells the local sequencer when to hold stepping.

## Interface
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `W`, 32: coordinate width (fixed-point, opaque to this block).
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low.
- `step_done`  in  1  single-cycle pulse; positions below are stable in this cycle.
- `first_x`, `first_y`  in  W each  position of node 0.
- `last_x`, `last_y`  in  W each  position of node N-1.
- `l_valid`  out  1  left packet available.
- `l_ready`  in  1  left consumer accepts.
- `l_x`, `l_y`  out  W each  left packet payload (first-node position).
- `l_seq`  out  8  left packet step tag.
- `r_valid`, `r_ready`, `r_x`, `r_y`, `r_seq`: same as the left channel; payload is the last-node position.
- `full`  out  1  either FIFO holds DEPTH entries.
- `overflow`  out  1  sticky; set on any drop/overwrite event.
- `drop_count`  out  16  count of step_done events that lost data on ≥1 channel; saturates at 0xFFFF.

## Operation
- Each channel is a circular FIFO with registered `wr_ptr`/`rd_ptr` (log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty). Entries are {x, y, seq}.
- Push happens on `step_done`. Left pushes {first_x, first_y, seq_ctr}; right pushes {last_x, last_y, seq_ctr}.
- Pop happens on `valid && ready`, independently per channel.
- `valid` = FIFO not empty. Payload outputs are driven from the head entry and are 0 whenever `valid` is 0.
- `seq_ctr` is 8-bit and increments (wrapping 255→0) on every `step_done`, including dropped ones, so consumers see a gap.
- Full channel, push without pop: new data is dropped and the FIFO is unchanged (default build).
- Full channel, simultaneous push and pop: the pop frees a slot, the push is accepted, and nothing is dropped.
- Drop accounting, on any step_done where ≥1 channel lost data:
  - `overflow` is set.
  - `drop_count` increments once, even if both channels lost data.
- `full` = left full OR right full. It is combinational from the pointers.
- Payload must stay stable while `valid` is high and `ready` is low.
- Reset:
  - pointers 0, `seq_ctr` 0, `overflow` 0, `drop_count` 0;
  - hence `l_valid` = `r_valid` = 0, `full` 0, payloads 0;
  - FIFO storage contents are don't-care.
- Reset asserted mid-transfer discards all queued packets. A `step_done` in a reset cycle is ignored.

## Timing
- Push latency: `step_done` at cycle N → `valid` high at cycle N+1 if the FIFO was empty. There is no combinational bypass from `step_done` to `valid`.
- Pop: a handshake at cycle N → the next entry (or `valid` low) is visible at cycle N+1.
- Throughput: one packet per cycle per channel.
- `full` rises the cycle after the DEPTH-th unpopped push.
- `seq_ctr` updates on the same edge as the push; packet k carries tag k mod 256.
- `drop_count` and `overflow` update on the edge that samples the losing `step_done`.

## Configuration
- `EDGE_TX_OVERWRITE_EN` defined: a full channel with push and no pop overwrites its newest entry (at `wr_ptr-1`) with the new payload and tag. Pointers are unchanged.
  - Consumers therefore always receive the most recent position.
  - `overflow` and `drop_count` still update.
  - The head entry is never overwritten unless DEPTH entries are all pending and the head is also the newest entry, which is impossible for DEPTH ≥ 2.
- Undefined: drop-new behaviour as described in Operation.

## Test plan
- Reset, then one `step_done` with first=(0x10,0x20), last=(0x30,0x40), both readies high:
  - cycle+1: `l_valid`=`r_valid`=1, `l_x`=0x10, `r_y`=0x40, both seq=0;
  - cycle+2: both `valid` low.
- `l_ready`=0, `r_ready`=1, 4 pushes (DEPTH=4) → `full`=1 after the 4th, right side drained in order with seq 0..3; left holds seq 0 stable.
- Left full, 5th `step_done` with no pop:
  - default build: seq 4 dropped, `overflow`=1, `drop_count`=1, left later drains seq 0,1,2,3;
  - with `EDGE_TX_OVERWRITE_EN`: drains 0,1,2,4.
- Left full, `step_done` in the same cycle as a left handshake → no drop, `drop_count` stays 0, left later drains seq 1,2,3,4.
- 256+ pushes with readies high → `l_seq` wraps 255→0. Separately, 65 540 forced drops → `drop_count` saturates at 0xFFFF.
- Reset low for one cycle with 3 packets queued → both `valid` 0 next cycle, counters 0, and the next push carries seq 0.
